// File: rtl/hamming_pkg.sv
// Shared types and codeword-layout helpers for the extended-Hamming SECDED decoder.
package hamming_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    SGL  = 2'b01,
    DBL  = 2'b10
  } secded_status_t;

  // Position 0 (overall parity) and every power of two hold parity, not data.
  function automatic bit is_parity_pos(input int i);
    return (i == 0) || ((i & (i - 1)) == 0);
  endfunction

  // Codeword index of data bit k (k starts at 1).
  function automatic int data_pos(input int k);
    int cnt;
    cnt = 0;
    for (int i = 3; i < 128; i++) begin
      if (!is_parity_pos(i)) begin
        cnt++;
        if (cnt == k) return i;
      end
    end
    return 0;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of one codeword.
module secded_syndrome #(
  parameter int R = 4
) (
  input  logic [(1<<R)-1:0] i_code,
  output logic [R-1:0]      o_syn,
  output logic              o_par
);

  localparam int N = 1 << R;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    o_syn = '0;
    for (int i = 1; i < N; i++) begin
      if (i_code[i]) o_syn = o_syn ^ R'(i);
    end
    o_par = ^i_code;
  end

endmodule

// File: rtl/hamming_secded_dec.sv
// Two-stage elastic SECDED decoder: stage 1 holds code/syndrome, stage 2 holds the output word.
// Optional error counters are built only when SECDED_ERR_CNT_EN is defined.
module hamming_secded_dec
  import hamming_pkg::*;
#(
  parameter  int R     = 4,
  parameter  int CNT_W = 16,
  localparam int N     = 1 << R,
  localparam int K     = N - 1 - R
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_word,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_sgl,
  output logic [CNT_W-1:0] cnt_dbl
);

  logic           w_s2_can_load;
  logic           w_in_fire;
  logic           w_s1_fire;
  logic [R-1:0]   w_syn;
  logic           w_par;
  logic [N-1:0]   w_corr;
  logic [K-1:0]   w_data;
  secded_status_t w_status;
  logic [N-1:0]   w_word;
  logic           w_unused_corr;

  logic           r_s1_valid;
  logic [N-1:0]   r_s1_code;
  logic [R-1:0]   r_s1_syn;
  logic           r_s1_par;
  logic           r_out_valid;
  logic [N-1:0]   r_out_word;

  secded_syndrome #(.R(R)) u_syndrome (
    .i_code (in_code),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  assign w_s2_can_load = !r_out_valid || out_ready;
  assign in_ready      = !r_s1_valid || w_s2_can_load;
  assign w_in_fire     = in_valid && in_ready;
  assign w_s1_fire     = r_s1_valid && w_s2_can_load;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_code  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_code  <= in_code;
      r_s1_syn   <= w_syn;
      r_s1_par   <= w_par;
    end else if (w_s1_fire) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Odd overall parity means a single flip at position s (s=0 hits p0 only).
  always_comb begin
    w_corr = r_s1_code;
    if (r_s1_par) w_corr[r_s1_syn] = ~r_s1_code[r_s1_syn];
    w_data = '0;
    for (int k = 1; k <= K; k++) begin
      w_data[k-1] = w_corr[data_pos(k)];
    end
    if (r_s1_par)               w_status = SGL;
    else if (r_s1_syn != '0)    w_status = DBL;
    else                        w_status = NONE;
  end

  assign w_word        = {w_status, {(R-1){1'b0}}, w_data};
  assign w_unused_corr = ^w_corr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
    end else if (w_s1_fire) begin
      r_out_valid <= 1'b1;
      r_out_word  <= w_word;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;

`ifdef SECDED_ERR_CNT_EN
  logic             w_out_fire;
  logic             w_inc_sgl;
  logic             w_inc_dbl;
  logic [CNT_W-1:0] r_cnt_sgl;
  logic [CNT_W-1:0] r_cnt_dbl;

  assign w_out_fire = r_out_valid && out_ready;
  assign w_inc_sgl  = w_out_fire && (r_out_word[N-1:N-2] == SGL);
  assign w_inc_dbl  = w_out_fire && r_out_word[N-1];

  // Clear takes priority over a coincident increment; counts stick at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt_sgl <= '0;
      r_cnt_dbl <= '0;
    end else begin
      if (cnt_clr)                          r_cnt_sgl <= '0;
      else if (w_inc_sgl && r_cnt_sgl != '1) r_cnt_sgl <= r_cnt_sgl + CNT_W'(1);
      if (cnt_clr)                          r_cnt_dbl <= '0;
      else if (w_inc_dbl && r_cnt_dbl != '1) r_cnt_dbl <= r_cnt_dbl + CNT_W'(1);
    end
  end

  assign cnt_sgl = r_cnt_sgl;
  assign cnt_dbl = r_cnt_dbl;
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign cnt_sgl      = '0;
  assign cnt_dbl      = '0;
`endif

endmodule
